// File: rtl/stat_report_framer_pkg.sv
// Shared definitions for the pet status report framer and its host-side decoder.
package stat_report_framer_pkg;

  localparam int FRAME_LEN = 7;
  localparam int IDX_W     = 3;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  typedef logic [IDX_W-1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

endpackage

// File: rtl/stat_report_framer_if.sv
// Valid/ready byte stream from the framer to the UART transmitter.
interface stat_report_framer_if
  import stat_report_framer_pkg::*;
  ();

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/stat_report_framer_report_trigger.sv
// Decides when a report frame should start: divides the one-second tick,
// merges host requests, and remembers one trigger that arrives while a
// frame is already on the wire. Further triggers are counted as overruns.
module report_trigger
  import stat_report_framer_pkg::*;
#(
  parameter logic [7:0] PERIOD_TICKS = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       req_i,
  input  logic       busy_i,
  output logic       start_o,
  output logic [7:0] overrun_cnt_o
);

  localparam logic [7:0] LAST_TICK = PERIOD_TICKS - 8'd1;

  logic [7:0] tickCnt_q, tickCnt_d;
  logic       pending_q, pending_d;
  logic [7:0] overrun_q, overrun_d;
  logic       tickHit;
  logic       trigger;

  // Tick divider, trigger merge and the single-deep pending slot.
  always_comb begin
    tickCnt_d = tickCnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    tickHit   = 1'b0;

    if ((PERIOD_TICKS != 8'd0) && tick_i) begin
      if (tickCnt_q == LAST_TICK) begin
        tickCnt_d = 8'd0;
        tickHit   = 1'b1;
      end else begin
        tickCnt_d = tickCnt_q + 8'd1;
      end
    end

    trigger = req_i | tickHit;
    start_o = !busy_i && (trigger || pending_q);

    if (busy_i) begin
      if (trigger) begin
        if (!pending_q) begin
          pending_d = 1'b1;
        end else if (overrun_q != 8'hFF) begin
          overrun_d = overrun_q + 8'd1;
        end
      end
    end else if (start_o) begin
      pending_d = 1'b0;
    end
  end

  // Trigger-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tickCnt_q <= 8'd0;
      pending_q <= 1'b0;
      overrun_q <= 8'd0;
    end else begin
      tickCnt_q <= tickCnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun_cnt_o = overrun_q;

endmodule

// File: rtl/stat_report_framer.sv
// Snapshots the six pet stats plus the status byte and streams them out as a
// 7-byte frame: header, three packed stat bytes, status, sequence, XOR checksum.
module stat_report_framer
  import stat_report_framer_pkg::*;
#(
  parameter logic [7:0] HEADER       = HEADER_DEFAULT,
  parameter logic [7:0] PERIOD_TICKS = 8'd1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        req,
  input  logic [3:0]                  hunger,
  input  logic [3:0]                  happiness,
  input  logic [3:0]                  health,
  input  logic [3:0]                  hygiene,
  input  logic [3:0]                  energy,
  input  logic [3:0]                  social,
  input  logic [7:0]                  status,
  stat_report_framer_if.master        tx,
  output logic                        busy,
  output logic [7:0]                  seq,
  output logic [7:0]                  overrun_cnt
);

  state_e    state_q, state_d;
  byte_idx_t byteIdx_q, byteIdx_d;
  byte_idx_t nextIdx;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  accChk;
  logic        txValid_q, txValid_d;
  logic [7:0]  txData_q, txData_d;
  logic        busy_q, busy_d;
  logic [7:0]  seq_q, seq_d;
  logic [23:0] statSnap_q, statSnap_d;
  logic [7:0]  statusSnap_q, statusSnap_d;
  logic [7:0]  seqSnap_q, seqSnap_d;
  logic        start;

  report_trigger #(
    .PERIOD_TICKS (PERIOD_TICKS)
  ) uTrigger (
    .clk           (clk),
    .reset         (reset),
    .tick_i        (tick),
    .req_i         (req),
    .busy_i        (state_q == SEND),
    .start_o       (start),
    .overrun_cnt_o (overrun_cnt)
  );

  // Frame sequencing: snapshot on start, then advance one byte per accepted transfer.
  always_comb begin
    state_d      = state_q;
    byteIdx_d    = byteIdx_q;
    chk_d        = chk_q;
    txValid_d    = txValid_q;
    txData_d     = txData_q;
    busy_d       = busy_q;
    seq_d        = seq_q;
    statSnap_d   = statSnap_q;
    statusSnap_d = statusSnap_q;
    seqSnap_d    = seqSnap_q;
    nextIdx      = byteIdx_q + byte_idx_t'(1);
    accChk       = chk_q ^ txData_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          statSnap_d   = {hunger, happiness, health, hygiene, energy, social};
          statusSnap_d = status;
          seqSnap_d    = seq_q;
          byteIdx_d    = '0;
          chk_d        = 8'd0;
          txValid_d    = 1'b1;
          txData_d     = HEADER;
          busy_d       = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (txValid_q && tx.tx_ready) begin
          chk_d = accChk;
          if (byteIdx_q == LAST_IDX) begin
            txValid_d = 1'b0;
            busy_d    = 1'b0;
            seq_d     = seq_q + 8'd1;
            state_d   = IDLE;
          end else begin
            byteIdx_d = nextIdx;
            case (nextIdx)
              3'd1:    txData_d = statSnap_q[23:16];
              3'd2:    txData_d = statSnap_q[15:8];
              3'd3:    txData_d = statSnap_q[7:0];
              3'd4:    txData_d = statusSnap_q;
              3'd5:    txData_d = seqSnap_q;
              default: txData_d = accChk;
            endcase
          end
        end
      end
    endcase
  end

  // Framer state registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      byteIdx_q    <= '0;
      chk_q        <= 8'd0;
      txValid_q    <= 1'b0;
      txData_q     <= 8'd0;
      busy_q       <= 1'b0;
      seq_q        <= 8'd0;
      statSnap_q   <= 24'd0;
      statusSnap_q <= 8'd0;
      seqSnap_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      byteIdx_q    <= byteIdx_d;
      chk_q        <= chk_d;
      txValid_q    <= txValid_d;
      txData_q     <= txData_d;
      busy_q       <= busy_d;
      seq_q        <= seq_d;
      statSnap_q   <= statSnap_d;
      statusSnap_q <= statusSnap_d;
      seqSnap_q    <= seqSnap_d;
    end
  end

  assign tx.tx_valid = txValid_q;
  assign tx.tx_data  = txData_q;
  assign busy        = busy_q;
  assign seq         = seq_q;

endmodule

// File: tb/tb_stat_report_framer.sv
// Testbench for stat_report_framer: three instances (tick period 1, 3 and
// disabled) share stimulus; frames are compared against a byte-level model.
module tb_stat_report_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       req = 1'b0;
  logic [3:0] hunger = 4'd0, happiness = 4'd0, health = 4'd0;
  logic [3:0] hygiene = 4'd0, energy = 4'd0, social = 4'd0;
  logic [7:0] status = 8'd0;
  logic       readyDrive = 1'b0;

  logic       busyM, busy3, busy0;
  logic [7:0] seqM, seq3, seq0;
  logic [7:0] ovM, ov3, ov0;

  int cycle = 0;
  int checks = 0;
  int errors = 0;
  int stabErr = 0;

  logic [7:0] mainQ[$];
  int         mainCyc[$];
  logic [7:0] q3[$];
  logic [7:0] q0[$];
  logic [7:0] expQ[$];
  logic [7:0] expBytes[7];
  logic       holdPrev = 1'b0;
  logic [7:0] holdData = 8'd0;

  stat_report_framer_if busMain ();
  stat_report_framer_if bus3 ();
  stat_report_framer_if bus0 ();

  assign busMain.tx_ready = readyDrive;
  assign bus3.tx_ready    = readyDrive;
  assign bus0.tx_ready    = readyDrive;

  stat_report_framer #(.PERIOD_TICKS(8'd1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social), .status(status),
    .tx(busMain), .busy(busyM), .seq(seqM), .overrun_cnt(ovM)
  );

  stat_report_framer #(.PERIOD_TICKS(8'd3)) dut3 (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social), .status(status),
    .tx(bus3), .busy(busy3), .seq(seq3), .overrun_cnt(ov3)
  );

  stat_report_framer #(.PERIOD_TICKS(8'd0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .social(social), .status(status),
    .tx(bus0), .busy(busy0), .seq(seq0), .overrun_cnt(ov0)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Capture every accepted byte just before the edge that transfers it,
  // and flag any byte that is withdrawn or changed while held off.
  always @(negedge clk) begin
    if (!reset && busMain.tx_valid && busMain.tx_ready) begin
      mainQ.push_back(busMain.tx_data);
      mainCyc.push_back(cycle);
    end
    if (!reset && bus3.tx_valid && bus3.tx_ready) q3.push_back(bus3.tx_data);
    if (!reset && bus0.tx_valid && bus0.tx_ready) q0.push_back(bus0.tx_data);
    if (holdPrev && !reset && (busMain.tx_valid !== 1'b1 || busMain.tx_data !== holdData))
      stabErr = stabErr + 1;
    holdPrev = busMain.tx_valid && !busMain.tx_ready && !reset;
    holdData = busMain.tx_data;
  end

  // Reference frame: header, packed stats, status, sequence, XOR of the first six.
  function automatic void buildFrame(input logic [23:0] s, input logic [7:0] st,
                                     input logic [7:0] sq);
    expBytes[0] = 8'hA5;
    expBytes[1] = s[23:16];
    expBytes[2] = s[15:8];
    expBytes[3] = s[7:0];
    expBytes[4] = st;
    expBytes[5] = sq;
    expBytes[6] = 8'h00;
    for (int i = 0; i < 6; i++) expBytes[6] = expBytes[6] ^ expBytes[i];
  endfunction

  task automatic setStats(input logic [23:0] s, input logic [7:0] st);
    {hunger, happiness, health, hygiene, energy, social} = s;
    status = st;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick  = 1'b0;
    req   = 1'b0;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    mainQ.delete();
    mainCyc.delete();
    q3.delete();
    q0.delete();
    stabErr = 0;
  endtask

  task automatic pulseReq();
    req = 1'b1;
    nextCycle();
    req = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget, input string name);
    int c = 0;
    while (mainQ.size() < n && c < budget) begin
      nextCycle();
      c++;
    end
    checks++;
    if (mainQ.size() < n) begin
      errors++;
      $display("[TB] FAIL %s timeout: got %0d bytes, required %0d", name, mainQ.size(), n);
    end
  endtask

  task automatic test_reset();
    doReset();
    checks += 5;
    if (busMain.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset tx_valid: got %b, required 0", busMain.tx_valid); end
    if (busMain.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset tx_data: got %h, required 00", busMain.tx_data); end
    if (busyM !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b, required 0", busyM); end
    if (seqM !== 8'h00) begin errors++; $display("[TB] FAIL reset seq: got %h, required 00", seqM); end
    if (ovM !== 8'h00) begin errors++; $display("[TB] FAIL reset overrun: got %h, required 00", ovM); end
  endtask

  task automatic test_single_frame();
    logic [7:0] ref1[7];
    logic [7:0] got;
    int span;
    ref1 = '{8'hA5, 8'h3A, 8'hF0, 8'h5C, 8'h21, 8'h00, 8'h12};
    doReset();
    setStats(24'h3AF05C, 8'h21);
    readyDrive = 1'b1;
    pulseReq();
    waitBytes(7, 30, "single");
    for (int i = 0; i < 7; i++) begin
      got = (i < mainQ.size()) ? mainQ[i] : 8'hxx;
      checks++;
      if (got !== ref1[i]) begin errors++; $display("[TB] FAIL single byte%0d: got %h, required %h", i, got, ref1[i]); end
    end
    span = (mainCyc.size() >= 7) ? (mainCyc[6] - mainCyc[0]) : -1;
    checks += 4;
    if (span != 6) begin errors++; $display("[TB] FAIL single span: got %0d, required 6", span); end
    if (seqM !== 8'h01) begin errors++; $display("[TB] FAIL single seq: got %h, required 01", seqM); end
    if (busyM !== 1'b0) begin errors++; $display("[TB] FAIL single busy: got %b, required 0", busyM); end
    if (busMain.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL single valid: got %b, required 0", busMain.tx_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ref1[7];
    logic [7:0] got;
    int span;
    int c;
    ref1 = '{8'hA5, 8'h3A, 8'hF0, 8'h5C, 8'h21, 8'h00, 8'h12};
    doReset();
    setStats(24'h3AF05C, 8'h21);
    readyDrive = 1'b0;
    pulseReq();
    readyDrive = 1'b1;
    c = 0;
    while (mainQ.size() < 7 && c < 40) begin
      nextCycle();
      readyDrive = ~readyDrive;
      c++;
    end
    readyDrive = 1'b1;
    for (int i = 0; i < 7; i++) begin
      got = (i < mainQ.size()) ? mainQ[i] : 8'hxx;
      checks++;
      if (got !== ref1[i]) begin errors++; $display("[TB] FAIL backpressure byte%0d: got %h, required %h", i, got, ref1[i]); end
    end
    span = (mainCyc.size() >= 7) ? (mainCyc[6] - mainCyc[0]) : -1;
    checks += 2;
    if (span != 12) begin errors++; $display("[TB] FAIL backpressure span: got %0d, required 12", span); end
    if (stabErr != 0) begin errors++; $display("[TB] FAIL backpressure stability: got %0d violations, required 0", stabErr); end
  endtask

  task automatic test_snapshot();
    logic [7:0] ref1[7];
    logic [7:0] got;
    ref1 = '{8'hA5, 8'h3A, 8'hF0, 8'h5C, 8'h21, 8'h00, 8'h12};
    doReset();
    setStats(24'h3AF05C, 8'h21);
    readyDrive = 1'b1;
    pulseReq();
    setStats(24'hFFFFFF, 8'hFF);
    waitBytes(7, 30, "snapshot");
    for (int i = 1; i < 7; i++) begin
      got = (i < mainQ.size()) ? mainQ[i] : 8'hxx;
      checks++;
      if (got !== ref1[i]) begin errors++; $display("[TB] FAIL snapshot byte%0d: got %h, required %h", i, got, ref1[i]); end
    end
  endtask

  task automatic test_periodic();
    logic [23:0] s;
    logic [7:0]  st;
    logic [7:0]  got;
    doReset();
    s  = 24'($urandom);
    st = 8'($urandom);
    setStats(s, st);
    readyDrive = 1'b1;
    for (int t = 0; t < 9; t++) begin
      tick = 1'b1;
      nextCycle();
      tick = 1'b0;
      repeat (11) nextCycle();
    end
    checks += 3;
    if (q3.size() != 21) begin errors++; $display("[TB] FAIL period3 count: got %0d bytes, required 21", q3.size()); end
    if (q0.size() != 0) begin errors++; $display("[TB] FAIL period0 count: got %0d bytes, required 0", q0.size()); end
    if (mainQ.size() != 63) begin errors++; $display("[TB] FAIL period1 count: got %0d bytes, required 63", mainQ.size()); end
    for (int f = 0; f < 3; f++) begin
      buildFrame(s, st, 8'(f));
      for (int i = 0; i < 7; i++) begin
        got = (f * 7 + i < q3.size()) ? q3[f * 7 + i] : 8'hxx;
        checks++;
        if (got !== expBytes[i]) begin errors++; $display("[TB] FAIL period3 frame%0d byte%0d: got %h, required %h", f, i, got, expBytes[i]); end
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] got;
    int gap;
    doReset();
    setStats(24'h3AF05C, 8'h21);
    readyDrive = 1'b0;
    pulseReq();
    repeat (4) begin
      pulseReq();
      nextCycle();
    end
    checks += 3;
    if (ovM !== 8'd3) begin errors++; $display("[TB] FAIL overrun count: got %0d, required 3", ovM); end
    if (dut.uTrigger.pending_q !== 1'b1) begin errors++; $display("[TB] FAIL overrun pending: got %b, required 1", dut.uTrigger.pending_q); end
    if (busyM !== 1'b1) begin errors++; $display("[TB] FAIL overrun busy: got %b, required 1", busyM); end
    readyDrive = 1'b1;
    waitBytes(14, 60, "overrun");
    repeat (10) nextCycle();
    for (int f = 0; f < 2; f++) begin
      buildFrame(24'h3AF05C, 8'h21, 8'(f));
      for (int i = 0; i < 7; i++) begin
        got = (f * 7 + i < mainQ.size()) ? mainQ[f * 7 + i] : 8'hxx;
        checks++;
        if (got !== expBytes[i]) begin errors++; $display("[TB] FAIL overrun frame%0d byte%0d: got %h, required %h", f, i, got, expBytes[i]); end
      end
    end
    gap = (mainCyc.size() >= 8) ? (mainCyc[7] - mainCyc[6]) : -1;
    checks += 4;
    if (gap != 2) begin errors++; $display("[TB] FAIL overrun gap: got %0d, required 2", gap); end
    if (mainQ.size() != 14) begin errors++; $display("[TB] FAIL overrun total: got %0d bytes, required 14", mainQ.size()); end
    if (seqM !== 8'd2) begin errors++; $display("[TB] FAIL overrun seq: got %h, required 02", seqM); end
    if (ovM !== 8'd3) begin errors++; $display("[TB] FAIL overrun hold: got %0d, required 3", ovM); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] got;
    doReset();
    setStats(24'h3AF05C, 8'h21);
    readyDrive = 1'b1;
    pulseReq();
    waitBytes(4, 20, "midframe");
    reset = 1'b1;
    nextCycle();
    checks += 3;
    if (busMain.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset valid: got %b, required 0", busMain.tx_valid); end
    if (busyM !== 1'b0) begin errors++; $display("[TB] FAIL midreset busy: got %b, required 0", busyM); end
    if (seqM !== 8'h00) begin errors++; $display("[TB] FAIL midreset seq: got %h, required 00", seqM); end
    reset = 1'b0;
    repeat (5) nextCycle();
    checks++;
    if (mainQ.size() != 4) begin errors++; $display("[TB] FAIL midreset leftover: got %0d bytes, required 4", mainQ.size()); end
    mainQ.delete();
    mainCyc.delete();
    pulseReq();
    waitBytes(7, 30, "midreset refill");
    buildFrame(24'h3AF05C, 8'h21, 8'h00);
    for (int i = 0; i < 7; i++) begin
      got = (i < mainQ.size()) ? mainQ[i] : 8'hxx;
      checks++;
      if (got !== expBytes[i]) begin errors++; $display("[TB] FAIL midreset byte%0d: got %h, required %h", i, got, expBytes[i]); end
    end
  endtask

  task automatic test_random();
    logic [23:0] s;
    logic [7:0]  st;
    logic [7:0]  got;
    int c;
    doReset();
    expQ.delete();
    for (int f = 0; f < 20; f++) begin
      s  = 24'($urandom);
      st = 8'($urandom);
      setStats(s, st);
      buildFrame(s, st, 8'(f));
      for (int i = 0; i < 7; i++) expQ.push_back(expBytes[i]);
      readyDrive = 1'($urandom);
      pulseReq();
      setStats(24'($urandom), 8'($urandom));
      c = 0;
      while (mainQ.size() < (f + 1) * 7 && c < 200) begin
        readyDrive = (($urandom % 4) != 0);
        nextCycle();
        c++;
      end
      readyDrive = 1'b1;
      nextCycle();
    end
    checks += 3;
    if (mainQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL random count: got %0d bytes, required %0d", mainQ.size(), expQ.size()); end
    if (seqM !== 8'd20) begin errors++; $display("[TB] FAIL random seq: got %0d, required 20", seqM); end
    if (stabErr != 0) begin errors++; $display("[TB] FAIL random stability: got %0d violations, required 0", stabErr); end
    for (int i = 0; i < expQ.size(); i++) begin
      got = (i < mainQ.size()) ? mainQ[i] : 8'hxx;
      checks++;
      if (got !== expQ[i]) begin errors++; $display("[TB] FAIL random byte%0d: got %h, required %h", i, got, expQ[i]); end
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_snapshot();
    test_periodic();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck design still terminates the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
